// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if
// Bundles the register file's write-back and operand-fetch signals so the
// datapath and the register file connect through one port.
//
// Signals:
//   reg_write  write enable from control
//   wr         write register address (the selected destination field)
//   wd         write-back data
//   rr1, rr2   operand read addresses
//   rd1, rd2   operand read data
//   ready      high once the register file has finished clearing itself
//
// Modports:
//   master  datapath side: drives addresses/data, receives read data and ready
//   slave   register file side
// ---------------------------------------------------------------------------
interface reg_file_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);

   logic              reg_write;
   logic [ADDR_W-1:0] wr;
   logic [DATA_W-1:0] wd;
   logic [ADDR_W-1:0] rr1;
   logic [ADDR_W-1:0] rr2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              ready;

   modport master (
      output reg_write,
      output wr,
      output wd,
      output rr1,
      output rr2,
      input  rd1,
      input  rd2,
      input  ready
   );

   modport slave (
      input  reg_write,
      input  wr,
      input  wd,
      input  rr1,
      input  rr2,
      output rd1,
      output rd2,
      output ready
   );

endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// General register file: 2^ADDR_W registers of DATA_W bits, two combinational
// read ports for operand fetch and one synchronous write port for write-back.
// The storage is meant to map onto distributed RAM, which cannot be reset in
// bulk, so after reset a small FSM walks every entry and writes zero into it.
// Until that sweep completes, ready stays low, writes are dropped and both
// read ports return zero.
//
// Parameters:
//   DATA_W  register width
//   ADDR_W  register address width (depth = 2^ADDR_W)
//   BYPASS  1 = a read of the register being written this cycle returns the
//           write data; 0 = it returns the stored (old) value
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high; restarts the clearing sweep
//   bus    reg_file_if slave modport (reg_write, wr, wd, rr1, rr2 in;
//          rd1, rd2, ready out)
// ---------------------------------------------------------------------------
module reg_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int BYPASS = 1
) (
   input  logic       clk,
   input  logic       reset,
   reg_file_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;
   localparam bit BYP_EN = (BYPASS != 0);

   // INIT is the clearing sweep, RUN is normal operation.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   // Single physical write port into the array, shared between the sweep
   // and normal write-back.
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   logic [DATA_W-1:0] mem [DEPTH];

   // State and sweep pointer. Reset always returns to the start of the
   // sweep, whether it arrives mid-sweep or during normal operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state and write-port selection. During the sweep the write port is
   // owned by the FSM, so any write-back request in that window is lost;
   // upstream stall logic is expected to wait for ready. Once the last entry
   // is cleared the pointer wraps to zero and is simply held in RUN.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mem_we  = 1'b0;
      mem_wa  = bus.wr;
      mem_wd  = bus.wd;
      case (state_q)
         INIT: begin
            mem_we = 1'b1;
            mem_wa = ptr_q;
            mem_wd = '0;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            mem_we = bus.reg_write;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Storage array. It has no reset of its own; the reset edge itself writes
   // nothing, so a write coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // ready comes straight from the state register, so it has no
   // combinational path from any input.
   assign bus.ready = (state_q == RUN);

   // Read port 1. Forced to zero during the sweep because entries not yet
   // cleared still hold whatever the RAM powered up with.
   always_comb begin
      bus.rd1 = mem[bus.rr1];
      if (state_q != RUN) begin
         bus.rd1 = '0;
      end else if (BYP_EN && bus.reg_write && (bus.rr1 == bus.wr)) begin
         bus.rd1 = bus.wd;
      end
   end

   // Read port 2, identical rules to port 1 and independent of it.
   always_comb begin
      bus.rd2 = mem[bus.rr2];
      if (state_q != RUN) begin
         bus.rd2 = '0;
      end else if (BYP_EN && bus.reg_write && (bus.rr2 == bus.wr)) begin
         bus.rd2 = bus.wd;
      end
   end

endmodule
